// File: rtl/comp_arbiter_pkg.sv
// Shared constants for the comparator arbiter: FSM encoding, default sizes
// and a constant-foldable ceil(log2) used to validate the index width.
package comp_arbiter_pkg;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_EVAL = 1'b1;

   localparam int DEF_DATAWIDTH = 8;
   localparam int DEF_NUM_REQ   = 4;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/comp.sv
// Unsigned magnitude comparator shared by all requesters of comp_arbiter.
module comp #(
   parameter int DATAWIDTH = 8
) (
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   output logic                 gt,
   output logic                 lt,
   output logic                 eq
);

   assign gt = (a > b);
   assign lt = (a < b);
   assign eq = (a == b);

endmodule

// File: rtl/comp_arbiter_rr_pick.sv
// Round-robin winner selection: scans a doubled request vector starting at
// the pointer so the wrap-around needs no modulo arithmetic on the vector.
module comp_arbiter_rr_pick
   import comp_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [ID_W-1:0]    win_o,
   output logic               any_o
);

   logic [2*NUM_REQ-1:0] dbl_s;
   logic [ID_W:0]        idx_s;
   logic [ID_W:0]        wrap_s;
   logic                 found_s;

   assign dbl_s = {req_i, req_i};
   assign any_o = |req_i;

   always_comb begin
      win_o   = '0;
      found_s = 1'b0;
      idx_s   = '0;
      wrap_s  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx_s = {1'b0, ptr_i} + (ID_W+1)'(k);
         if (!found_s && dbl_s[idx_s]) begin
            found_s = 1'b1;
            // Fold the doubled-vector position back onto a requester index
            if (idx_s >= (ID_W+1)'(NUM_REQ)) begin
               wrap_s = idx_s - (ID_W+1)'(NUM_REQ);
            end else begin
               wrap_s = idx_s;
            end
            win_o = wrap_s[ID_W-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/comp_arbiter.sv
// Round-robin arbiter sharing one magnitude comparator among NUM_REQ
// requesters; grant latches operands, the following edge returns the result.
module comp_arbiter
   import comp_arbiter_pkg::*;
#(
   parameter int DATAWIDTH = DEF_DATAWIDTH,
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int ID_W      = 2
) (
   input  logic                         Clk,
   input  logic                         Rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*DATAWIDTH-1:0] a_in,
   input  logic [NUM_REQ*DATAWIDTH-1:0] b_in,
   output logic [NUM_REQ-1:0]           ack,
   output logic                         gt,
   output logic                         lt,
   output logic                         eq,
   output logic [ID_W-1:0]              res_id,
   output logic                         busy
);

   if (ID_W != clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_params
      $error("comp_arbiter: NUM_REQ must be 2..8 and ID_W must equal clog2(NUM_REQ)");
   end

   logic                 state_q, state_d;
   logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
   logic [DATAWIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic                 gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
   logic [ID_W-1:0]      res_id_q, res_id_d;
   logic [ID_W-1:0]      win_s;
   logic                 any_s;
   logic                 cmp_gt_s, cmp_lt_s, cmp_eq_s;

   comp_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
      .req_i (req),
      .ptr_i (rr_ptr_q),
      .win_o (win_s),
      .any_o (any_s)
   );

   comp #(.DATAWIDTH(DATAWIDTH)) u_comp (
      .a  (a_q),
      .b  (b_q),
      .gt (cmp_gt_s),
      .lt (cmp_lt_s),
      .eq (cmp_eq_s)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = ST_IDLE;
      case (state_q)
         ST_IDLE: state_d = any_s ? ST_EVAL : ST_IDLE;
         ST_EVAL: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      gnt_id_d = gnt_id_q;
      a_d      = a_q;
      b_d      = b_q;
      ack_d    = '0;
      gt_d     = gt_q;
      lt_d     = lt_q;
      eq_d     = eq_q;
      res_id_d = res_id_q;
      case (state_q)
         ST_IDLE: begin
            if (any_s) begin
               a_d      = a_in[int'(win_s)*DATAWIDTH +: DATAWIDTH];
               b_d      = b_in[int'(win_s)*DATAWIDTH +: DATAWIDTH];
               gnt_id_d = win_s;
            end else begin
               gnt_id_d = gnt_id_q;
            end
         end
         ST_EVAL: begin
            gt_d     = cmp_gt_s;
            lt_d     = cmp_lt_s;
            eq_d     = cmp_eq_s;
            res_id_d = gnt_id_q;
            ack_d    = NUM_REQ'(1) << gnt_id_q;
            // The just-served requester drops to lowest priority
            if (gnt_id_q == ID_W'(NUM_REQ-1)) begin
               rr_ptr_d = '0;
            end else begin
               rr_ptr_d = gnt_id_q + ID_W'(1);
            end
         end
         default: begin
            ack_d = '0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         rr_ptr_q <= '0;
         gnt_id_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         ack_q    <= '0;
         gt_q     <= 1'b0;
         lt_q     <= 1'b0;
         eq_q     <= 1'b0;
         res_id_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         gnt_id_q <= gnt_id_d;
         a_q      <= a_d;
         b_q      <= b_d;
         ack_q    <= ack_d;
         gt_q     <= gt_d;
         lt_q     <= lt_d;
         eq_q     <= eq_d;
         res_id_q <= res_id_d;
      end
   end

   assign ack    = ack_q;
   assign gt     = gt_q;
   assign lt     = lt_q;
   assign eq     = eq_q;
   assign res_id = res_id_q;
   assign busy   = (state_q != ST_IDLE);

endmodule
